if_prefetch_unit: RTL and testbench

Parametrised instruction-fetch front end that replaces the single-cycle fetch path with a decoupled prefetcher. It owns the fetch PC, issues one instruction-memory request at a time over a valid/ready handshake, and buffers returned instructions with their PCs in a DEPTH-entry queue. Branch and jump redirects flush the queue and discard any in-flight response. It sits between the PC-select logic of the IF stage and the IF/ID pipeline register, which it feeds over a valid/ready interface.

---
 rtl/if_prefetch_unit.sv | 122 ++++++++++++
 tb/tb_if_prefetch_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_unit.sv
// Decoupled instruction prefetcher: owns the fetch PC, keeps one memory request
// in flight and buffers returned instructions with their PCs in a ring queue.
module if_prefetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INSTR_W  = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 PC_STEP  = 4
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         PCWrite,
    input  logic                         BranchFlagID,
    input  logic [ADDR_W-1:0]            BrachAddress,
    input  logic                         JumpControl,
    input  logic [ADDR_W-1:0]            JumpAddress,
    output logic                         ImemReq,
    output logic [ADDR_W-1:0]            ImemAddr,
    input  logic                         ImemAck,
    input  logic                         ImemRspValid,
    input  logic [INSTR_W-1:0]           ImemRspData,
    output logic                         InstrValid,
    input  logic                         InstrReady,
    output logic [INSTR_W-1:0]           Instruction,
    output logic [ADDR_W-1:0]            InstrPC,
    output logic [ADDR_W-1:0]            PCAdder_Out,
    output logic [ADDR_W-1:0]            FetchPC,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0]  FULL = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_fetch_pc;
    logic [ADDR_W-1:0]    r_req_pc;
    logic [INSTR_W-1:0]   r_q_instr [DEPTH];
    logic [ADDR_W-1:0]    r_q_pc    [DEPTH];
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [CNT_W-1:0]     r_count;

    logic                 w_redirect;
    logic [ADDR_W-1:0]    w_target;
    logic                 w_xfer;
    logic                 w_push;
    logic                 w_pop;

    assign w_redirect  = BranchFlagID | JumpControl;
    assign w_target    = BranchFlagID ? BrachAddress : JumpAddress;
    // Reset term keeps the request low while the FSM is held in reset
    assign ImemReq     = Reset & (r_state == IDLE) & PCWrite & ~w_redirect & (r_count < FULL);
    assign w_xfer      = ImemReq & ImemAck;
    assign w_push      = (r_state == WAIT) & ImemRspValid & ~w_redirect;
    assign w_pop       = InstrValid & InstrReady & ~w_redirect;

    assign ImemAddr    = r_fetch_pc;
    assign FetchPC     = r_fetch_pc;
    assign Count       = r_count;
    assign InstrValid  = (r_count != '0);
    assign Instruction = r_q_instr[r_rd_ptr];
    assign InstrPC     = r_q_pc[r_rd_ptr];
    assign PCAdder_Out = r_q_pc[r_rd_ptr] + STEP;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
            end
        end else if (w_redirect) begin
            // Flush: queue emptied, an outstanding response becomes garbage
            r_fetch_pc <= w_target;
            r_count    <= '0;
            r_rd_ptr   <= r_wr_ptr;
            case (r_state)
                WAIT:    r_state <= ImemRspValid ? IDLE : DISCARD;
                DISCARD: r_state <= ImemRspValid ? IDLE : DISCARD;
                default: r_state <= IDLE;
            endcase
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_fetch_pc <= r_fetch_pc + STEP;
                        r_req_pc   <= r_fetch_pc;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (ImemRspValid) r_state <= IDLE;
                end
                DISCARD: begin
                    if (ImemRspValid) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (w_push) begin
                r_q_instr[r_wr_ptr] <= ImemRspData;
                r_q_pc[r_wr_ptr]    <= r_req_pc;
                r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Randomized bench for if_prefetch_unit: a variable-latency memory model drives
// the fetch port and a queue-based reference predicts every output each cycle.
module tb_if_prefetch_unit;
    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;
    localparam int STEP    = 4;

    logic                 Clock = 1'b0;
    logic                 Reset;
    logic                 PCWrite;
    logic                 BranchFlagID;
    logic [ADDR_W-1:0]    BrachAddress;
    logic                 JumpControl;
    logic [ADDR_W-1:0]    JumpAddress;
    logic                 ImemReq;
    logic [ADDR_W-1:0]    ImemAddr;
    logic                 ImemAck;
    logic                 ImemRspValid;
    logic [INSTR_W-1:0]   ImemRspData;
    logic                 InstrValid;
    logic                 InstrReady;
    logic [INSTR_W-1:0]   Instruction;
    logic [ADDR_W-1:0]    InstrPC;
    logic [ADDR_W-1:0]    PCAdder_Out;
    logic [ADDR_W-1:0]    FetchPC;
    logic [2:0]           Count;

    if_prefetch_unit #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH),
        .RESET_PC(32'h0), .PC_STEP(STEP)
    ) dut (
        .Clock(Clock), .Reset(Reset), .PCWrite(PCWrite),
        .BranchFlagID(BranchFlagID), .BrachAddress(BrachAddress),
        .JumpControl(JumpControl), .JumpAddress(JumpAddress),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck),
        .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
        .InstrValid(InstrValid), .InstrReady(InstrReady),
        .Instruction(Instruction), .InstrPC(InstrPC),
        .PCAdder_Out(PCAdder_Out), .FetchPC(FetchPC), .Count(Count)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of {instr, pc}, fetch PC and in-flight bookkeeping
    logic [63:0]        m_q[$];
    logic [ADDR_W-1:0]  m_fpc;
    logic [ADDR_W-1:0]  m_reqpc;
    bit                 m_infl;
    bit                 m_keep;

    // Memory model: one outstanding request, response after a random latency
    bit                 mem_pend;
    int                 mem_cnt;
    logic [INSTR_W-1:0] mem_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fpc  = 32'h0;
        m_reqpc = 32'h0;
        m_infl = 1'b0;
        m_keep = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_req",    {63'd0, ImemReq},    64'd0);
        chk("rst_valid",  {63'd0, InstrValid}, 64'd0);
        chk("rst_instr",  {32'd0, Instruction}, 64'd0);
        chk("rst_pc",     {32'd0, InstrPC},    64'd0);
        chk("rst_pcadd",  {32'd0, PCAdder_Out}, 64'd4);
        chk("rst_fetch",  {32'd0, FetchPC},    64'd0);
        chk("rst_count",  {61'd0, Count},      64'd0);
    endtask

    function automatic logic [ADDR_W-1:0] rand_target();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF8;
        return {r[31:2], 2'b00};
    endfunction

    task automatic cycle(input int p_redir, input int p_ready, input int p_pcw,
                         input int max_lat, input int p_ack, input bit rst_low);
        bit redirect, exp_req, xfer, rv;
        logic [ADDR_W-1:0] target;
        logic [63:0] head;
        @(negedge Clock);
        rv = 1'b0;
        ImemRspData = $urandom;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                rv = 1'b1;
                ImemRspData = mem_data;
                mem_pend = 1'b0;
            end
        end else if ($urandom_range(0, 9) == 0) begin
            rv = 1'b1;
        end
        ImemRspValid = rv;
        ImemAck      = !mem_pend && ($urandom_range(0, 99) < p_ack);
        PCWrite      = ($urandom_range(0, 99) < p_pcw);
        InstrReady   = ($urandom_range(0, 99) < p_ready);
        BranchFlagID = ($urandom_range(0, 99) < p_redir);
        JumpControl  = ($urandom_range(0, 99) < p_redir);
        BrachAddress = rand_target();
        JumpAddress  = rand_target();
        #1;
        if (rst_low) begin
            check_reset_vals();
            return;
        end

        redirect = BranchFlagID | JumpControl;
        target   = BranchFlagID ? BrachAddress : JumpAddress;
        exp_req  = !m_infl && PCWrite && !redirect && (m_q.size() < DEPTH);
        chk("imem_req",  {63'd0, ImemReq},   {63'd0, exp_req});
        chk("imem_addr", {32'd0, ImemAddr},  {32'd0, m_fpc});
        chk("fetch_pc",  {32'd0, FetchPC},   {32'd0, m_fpc});
        chk("count",     {61'd0, Count},     64'(m_q.size()));
        chk("instr_vld", {63'd0, InstrValid}, {63'd0, (m_q.size() != 0)});
        if (m_q.size() != 0) begin
            head = m_q[0];
            chk("instr",    {32'd0, Instruction}, {32'd0, head[63:32]});
            chk("instr_pc", {32'd0, InstrPC},     {32'd0, head[31:0]});
            chk("pc_add",   {32'd0, PCAdder_Out}, {32'd0, head[31:0] + 32'(STEP)});
        end

        xfer = exp_req && ImemAck;
        if (redirect) begin
            m_fpc = target;
            m_q.delete();
            if (m_infl) begin
                if (ImemRspValid) m_infl = 1'b0;
                else m_keep = 1'b0;
            end
        end else begin
            if (m_q.size() != 0 && InstrReady) void'(m_q.pop_front());
            if (m_infl && ImemRspValid) begin
                if (m_keep) m_q.push_back({ImemRspData, m_reqpc});
                m_infl = 1'b0;
            end else if (xfer) begin
                m_reqpc = m_fpc;
                m_fpc   = m_fpc + 32'(STEP);
                m_infl  = 1'b1;
                m_keep  = 1'b1;
            end
        end
        if (xfer) begin
            mem_pend = 1'b1;
            mem_cnt  = $urandom_range(1, max_lat);
            mem_data = $urandom;
        end
    endtask

    initial begin
        Reset = 1'b0; PCWrite = 1'b1; BranchFlagID = 1'b0; JumpControl = 1'b0;
        BrachAddress = '0; JumpAddress = '0; ImemAck = 1'b0; ImemRspValid = 1'b0;
        ImemRspData = '0; InstrReady = 1'b0;
        mem_pend = 1'b0; mem_cnt = 0; mem_data = '0;
        model_reset();
        repeat (3) cycle(0, 0, 100, 1, 0, 1'b1);
        @(negedge Clock);
        Reset = 1'b1;

        // Sequential stream with single-cycle memory
        repeat (20)   cycle(0, 100, 100, 1, 100, 1'b0);
        // Fill the queue, then drain it
        repeat (20)   cycle(0, 0, 100, 2, 100, 1'b0);
        repeat (8)    cycle(0, 100, 100, 1, 100, 1'b0);
        // Issue stalled by hazard control
        repeat (10)   cycle(0, 50, 0, 3, 100, 1'b0);
        // Mixed traffic with redirects and slow memory
        repeat (1500) cycle(8, 60, 80, 3, 70, 1'b0);
        repeat (300)  cycle(25, 40, 90, 4, 80, 1'b0);

        // Asynchronous reset mid-run; a late response must be ignored afterwards
        @(negedge Clock);
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        check_reset_vals();
        repeat (2) cycle(0, 0, 100, 1, 0, 1'b1);
        @(negedge Clock);
        Reset = 1'b1;
        repeat (300)  cycle(8, 60, 80, 3, 70, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
